// File: rtl/vm_clkmon_if.sv
// Control/status bundle for vm_clkmon. Signal suffixes are from the monitor's
// point of view: _i is driven by the master, _o is driven by the monitor.
interface vm_clkmon_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [CNT_W-1:0] gate_len_i;
  logic [CNT_W-1:0] lo_lim_i;
  logic [CNT_W-1:0] hi_lim_i;
  logic             err_clr_i;
  logic             busy_o;
  logic [CNT_W-1:0] edge_cnt_o;
  logic             cnt_vld_o;
  logic             freq_err_o;
  logic [CNT_W-1:0] min_per_o;
  logic [CNT_W-1:0] max_per_o;

  modport master (
    output start_i, gate_len_i, lo_lim_i, hi_lim_i, err_clr_i,
    input  busy_o, edge_cnt_o, cnt_vld_o, freq_err_o, min_per_o, max_per_o
  );

  modport slave (
    input  start_i, gate_len_i, lo_lim_i, hi_lim_i, err_clr_i,
    output busy_o, edge_cnt_o, cnt_vld_o, freq_err_o, min_per_o, max_per_o
  );
endinterface

// File: rtl/vm_clkmon.sv
// Counts rising edges of an asynchronous monitored clock over a gate window.
// Optional edge-spacing statistics are compiled in with VM_CLKMON_PERIOD_STATS_EN.
//
// state | meaning
// IDLE  | waiting for start; limits and gate length latched on start
// ARM   | waiting for the first detected rise, which opens the window
// GATE  | counting rises while the window counter runs down to 0
// DONE  | result published for one cycle, then back to IDLE
module vm_clkmon #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // legal 2..4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      mon_clk_i,
  vm_clkmon_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 rise;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     lo_q;
  logic [CNT_W-1:0]     hi_q;
  logic [CNT_W-1:0]     win_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 busy_q;
  logic [CNT_W-1:0]     edge_cnt_q;
  logic                 vld_q;
  logic                 err_q;
  logic                 start_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], mon_clk_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign start_acc = (state_q == IDLE) && bus.start_i;

  // Count including a rise in the current cycle; saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != ONES)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= ONE;
      lo_q       <= '0;
      hi_q       <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      edge_cnt_q <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.err_clr_i) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            len_q   <= (bus.gate_len_i == '0) ? ONE : bus.gate_len_i;
            lo_q    <= bus.lo_lim_i;
            hi_q    <= bus.hi_lim_i;
            busy_q  <= 1'b1;
            state_q <= ARM;
          end
        end
        ARM: begin
          if (rise) begin
            win_q   <= len_q - ONE;
            cnt_q   <= ONE;
            state_q <= GATE;
          end
        end
        GATE: begin
          cnt_q <= cnt_d;
          if (win_q == '0) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            vld_q      <= 1'b1;
            edge_cnt_q <= cnt_d;
            // Placed after the err_clr clear so a simultaneous set wins.
            if ((cnt_d < lo_q) || (cnt_d > hi_q)) begin
              err_q <= 1'b1;
            end
          end else begin
            win_q <= win_q - ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.edge_cnt_o = edge_cnt_q;
  assign bus.cnt_vld_o  = vld_q;
  assign bus.freq_err_o = err_q;

`ifdef VM_CLKMON_PERIOD_STATS_EN
  logic [CNT_W-1:0] spc_q;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;

  // spc_q is loaded with 1 on a rise so it reads the full spacing at the next rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spc_q <= '0;
      min_q <= ONES;
      max_q <= '0;
    end else begin
      if (start_acc) begin
        min_q <= ONES;
        max_q <= '0;
      end
      if ((state_q == ARM) && rise) begin
        spc_q <= ONE;
      end else if (state_q == GATE) begin
        if (rise) begin
          spc_q <= ONE;
          if (spc_q < min_q) begin
            min_q <= spc_q;
          end
          if (spc_q > max_q) begin
            max_q <= spc_q;
          end
        end else if (spc_q != ONES) begin
          spc_q <= spc_q + ONE;
        end
      end
    end
  end

  assign bus.min_per_o = min_q;
  assign bus.max_per_o = max_q;
`else
  assign bus.min_per_o = ONES;
  assign bus.max_per_o = '0;
`endif

endmodule
